logic2_sweep_ctrl: RTL
======================

// Module: logic2_sweep_ctrl
// PURPOSE
//  Sequencer/checker for the 3-input logic2 gate.
//  - On start, drives every input combination onto the gate in order: idx 0..2**N_IN-1.
//  - After each drive, waits a settle window, then samples the gate output d.
//  - Builds the measured truth table, compares it with an expected table and reports pass/fail.
//  - Lives beside the gate instance; replaces the hand-timed #10 stimulus sequence.
// PARAMETERS
//  N_IN           3   gate input count; table width = 2**N_IN
//  SETTLE_CYCLES  2   cycles inputs are held before sampling; legal range >= 1
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous reset, active-high
//  start     in   1        begin a sweep; sampled only in IDLE
//  abort     in   1        cancel a sweep; has priority over start
//  exp_tbl   in   2**N_IN  expected d per index; bit i = expected d for index i
//  dut_in    out  N_IN     gate inputs {a,b,c}, a = MSB
//  dut_out   in   1        gate output d
//  busy      out  1        sweep in progress (states SETTLE, SAMPLE)
//  done      out  1        one-cycle pulse; high exactly while in state DONE
//  pass      out  1        measured table == exp_tbl; valid from done, held until next start
//  result    out  2**N_IN  measured truth table
//  err_cnt   out  N_IN+1   count of mismatching indices
//  fail_idx  out  N_IN     lowest mismatching index; 0 if no mismatch
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; idx 0; timer 0.
//  States and transitions:
//   - IDLE -> SETTLE: on start && !abort.
//     Same edge: idx=0, dut_in=0, result=0, err_cnt=0, fail_idx=0, pass=0, timer=SETTLE_CYCLES-1.
//   - SETTLE: hold dut_in; timer decrements; at timer==0 -> SAMPLE.
//   - SAMPLE (one cycle):
//     - result[idx] <= dut_out.
//     - Mismatch if dut_out !== exp_tbl[idx]; X or Z counts as a mismatch.
//     - On mismatch: err_cnt++; if this is the first mismatch, fail_idx <= idx.
//     - If idx == 2**N_IN-1 -> DONE; pass <= (no mismatch in the whole sweep).
//     - Otherwise: idx++, dut_in <= idx+1, timer reload -> SETTLE.
//   - DONE -> IDLE unconditionally after one cycle.
//  Timing:
//   - Each vector takes SETTLE_CYCLES+1 cycles.
//   - Start accepted at edge 0; vector i is sampled at edge (i+1)*(SETTLE_CYCLES+1).
//   - done is high for the cycle after the final sample edge; busy falls on that same edge.
//   - Defaults: final sample at edge 24, done high for edges 24..25.
//  Boundary conditions:
//   - start while busy or in DONE: ignored.
//   - start and abort together in IDLE: remain IDLE.
//   - abort in SETTLE/SAMPLE: next edge -> IDLE, dut_in=0, no done pulse, pass=0.
//     result and err_cnt keep their partial values.
//   - abort in DONE: no effect.
//   - rst asserted mid-sweep: immediately (asynchronously) returns all registers to reset values.
//   - idx wrap never occurs: the sweep terminates at the last index.
//   - exp_tbl is sampled in SAMPLE, not latched at start; it must stay stable during a sweep.
// STRUCTURE
//  - Shared header logic2_defs.vh holds the state encodings (IDLE, SETTLE, SAMPLE, DONE, 2 bits)
//    and the N_IN default.
//  - One sub-module, logic2_settle_timer: down-counter with load/zero flag, width $clog2(SETTLE_CYCLES).
//  - The gate instance remains outside this block.
// TESTING  (defaults; gate modelled as d = majority(a,b,c))
//  - exp_tbl=8'hE8, pulse start -> done at edge 24, pass=1, result=8'hE8, err_cnt=0, fail_idx=0.
//  - exp_tbl=8'hE9 -> pass=0, result=8'hE8, err_cnt=1, fail_idx=0.
//  - exp_tbl=8'h17 -> pass=0, err_cnt=8, fail_idx=0.
//  - Force d=1'bz for index 5 -> err_cnt=1, fail_idx=5, pass=0.
//  - Abort at edge 10 -> busy=0 and dut_in=0 at edge 11; no done pulse.
//    Then re-start -> clean full sweep, pass=1.
//  - start pulsed at edges 5 and 24 -> ignored; exactly one done pulse.
//  - rst at edge 13 -> all outputs 0 immediately (asynchronously); state stays IDLE until next start.

Source files
------------

// File: rtl/logic2_sweep_ctrl_pkg.sv
// Shared types and defaults for the logic2 gate sweep controller.
package logic2_sweep_ctrl_pkg;

  localparam int unsigned N_IN_DEFAULT          = 3;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Settle timer width; at least one bit so SETTLE_CYCLES=1 still builds
  function automatic int unsigned timer_width(input int unsigned settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/logic2_settle_timer.sv
// Loadable down-counter that measures the input settle window.
module logic2_settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load wins over decrement; counter parks at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= W'(count - 1'b1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/logic2_sweep_ctrl.sv
// Drives every input combination onto the logic2 gate, samples its output
// after a settle window and checks the measured truth table.
module logic2_sweep_ctrl
  import logic2_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(2**N_IN)-1:0]  exp_tbl,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(2**N_IN)-1:0]  result,
  output logic [N_IN:0]         err_cnt,
  output logic [N_IN-1:0]       fail_idx
);

  localparam int unsigned TBL_W = 2**N_IN;
  localparam int unsigned CNT_W = N_IN + 1;
  localparam int unsigned TW    = timer_width(SETTLE_CYCLES);

  state_t          state, state_d;
  logic [N_IN-1:0] idx;
  logic            timer_load_c, timer_dec_c, timer_zero_c;
  logic            mismatch_c, last_c;

  logic2_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_c),
    .dec      (timer_dec_c),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .zero_c   (timer_zero_c)
  );

  // X/Z on the gate output must count as a mismatch, hence the case inequality
  assign mismatch_c = (dut_out !== exp_tbl[idx]);
  assign last_c     = (idx == N_IN'(TBL_W - 1));

  // Next-state and timer control
  always_comb begin
    state_d      = state;
    timer_load_c = 1'b0;
    timer_dec_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d      = ST_SETTLE;
          timer_load_c = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (timer_zero_c) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec_c = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_c) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_SETTLE;
          timer_load_c = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus status flags decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done  <= (state_d == ST_DONE);
    end
  end

  // Sweep datapath: index, gate drive and measurement results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      dut_in   <= '0;
      result   <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            idx      <= '0;
            dut_in   <= '0;
            result   <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            idx    <= '0;
            dut_in <= '0;
            pass   <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            idx    <= '0;
            dut_in <= '0;
            pass   <= 1'b0;
          end else begin
            result[idx] <= dut_out;
            if (mismatch_c) begin
              err_cnt <= CNT_W'(err_cnt + 1'b1);
              if (err_cnt == '0) begin
                fail_idx <= idx;
              end
            end
            if (last_c) begin
              pass <= !mismatch_c && (err_cnt == '0);
            end else begin
              idx    <= N_IN'(idx + 1'b1);
              dut_in <= N_IN'(idx + 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
